// File: rtl/wb_reg_bank_pkg.sv
// Shared decode type and helpers for the wb_reg_bank Wishbone register bank.
package wb_reg_bank_pkg;

   typedef enum logic [2:0] {
      DEC_RW,
      DEC_STAT,
      DEC_PEND,
      DEC_MASK,
      DEC_ERR
   } dec_e;

   // Byte-lane merge on a 32-bit container; callers size-cast in and out.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
      logic [31:0] r;
      for (int k = 0; k < 4; k++)
         r[8*k +: 8] = sel[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
      return r;
   endfunction

   function automatic int log2_ceil(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/wb_reg_bank_irq.sv
// Interrupt word pair for wb_reg_bank: rising-edge PEND latch, MASK, registered irq_o.
module wb_reg_bank_irq
   import wb_reg_bank_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_W-1:0]     irq_src_i,
   input  logic                  pend_we,
   input  logic                  mask_we,
   input  logic [DATA_W/8-1:0]   sel_i,
   input  logic [DATA_W-1:0]     dat_i,
   output logic [DATA_W-1:0]     pend_o,
   output logic [DATA_W-1:0]     mask_o,
   output logic                  irq_o
);

   logic [DATA_W-1:0] src_q;
   logic [DATA_W-1:0] rise;
   logic [DATA_W-1:0] clr;

   assign rise = irq_src_i & ~src_q;
   assign clr  = pend_we ? DATA_W'(merge_lanes(32'd0, 32'(dat_i), 4'(sel_i))) : '0;

   // Set is OR-ed after the clear so a same-cycle edge survives.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q  <= '0;
         pend_o <= '0;
         mask_o <= '0;
         irq_o  <= 1'b0;
      end else begin
         src_q  <= irq_src_i;
         pend_o <= (pend_o & ~clr) | rise;
         if (mask_we)
            mask_o <= DATA_W'(merge_lanes(32'(mask_o), 32'(dat_i), 4'(sel_i)));
         irq_o  <= |(pend_o & mask_o);
      end
   end

endmodule

// File: rtl/wb_reg_bank.sv
// Wishbone classic slave register bank: NREG RW words, NSTAT RO status words.
// Defining WB_REG_BANK_IRQ_EN adds PEND/MASK words plus irq_src_i/irq_o ports.
module wb_reg_bank
   import wb_reg_bank_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADR_W  = 16,
   parameter int NREG   = 8,
   parameter int NSTAT  = 4,
   parameter int BASE   = 0
)(
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              cyc_i,
   input  logic                              stb_i,
   input  logic [ADR_W-1:0]                  adr_i,
   input  logic                              we_i,
   input  logic [DATA_W/8-1:0]               sel_i,
   input  logic [DATA_W-1:0]                 dat_i,
   output logic [DATA_W-1:0]                 dat_o,
   output logic                              ack_o,
   output logic                              err_o,
   output logic [NREG*DATA_W-1:0]            regs_o,
   output logic [NREG-1:0]                   wr_stb_o,
   input  logic [((NSTAT > 0) ? NSTAT : 1)*DATA_W-1:0] stat_i
`ifdef WB_REG_BANK_IRQ_EN
   ,
   input  logic [DATA_W-1:0]                 irq_src_i,
   output logic                              irq_o
`endif
);

   localparam int          MAXN  = (NREG > NSTAT) ? NREG : NSTAT;
   localparam int          IDX_W = log2_ceil((MAXN > 2) ? MAXN : 2);
   localparam logic [31:0] N_RW  = 32'(NREG);
   localparam logic [31:0] N_ST  = 32'(NREG + NSTAT);

   logic [ADR_W-1:0]  off;
   logic [31:0]       off32;
   dec_e              dec;
   logic [IDX_W-1:0]  idx;
   logic              req;
   logic              wr_req;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] pend_w;
   logic [DATA_W-1:0] mask_w;

   // Unsigned wrap makes addresses below BASE land far out of range.
   assign off    = adr_i - ADR_W'(BASE);
   assign off32  = 32'(off);
   assign req    = cyc_i & stb_i & ~ack_o & ~err_o;
   assign wr_req = req & we_i;

   always_comb begin
      dec = DEC_ERR;
      idx = '0;
      if (off32 < N_RW) begin
         dec = DEC_RW;
         idx = IDX_W'(off32);
      end else if (off32 < N_ST) begin
         dec = DEC_STAT;
         idx = IDX_W'(off32 - N_RW);
      end
`ifdef WB_REG_BANK_IRQ_EN
      else if (off32 == N_ST)
         dec = DEC_PEND;
      else if (off32 == N_ST + 32'd1)
         dec = DEC_MASK;
`endif
   end

   always_comb begin
      rd_word = '0;
      case (dec)
         DEC_RW:
            for (int i = 0; i < NREG; i++)
               if (idx == IDX_W'(i)) rd_word = regs_o[i*DATA_W +: DATA_W];
         DEC_STAT:
            for (int i = 0; i < NSTAT; i++)
               if (idx == IDX_W'(i)) rd_word = stat_i[i*DATA_W +: DATA_W];
         DEC_PEND: rd_word = pend_w;
         DEC_MASK: rd_word = mask_w;
         default:  rd_word = '0;
      endcase
   end

   for (genvar g = 0; g < NREG; g++) begin : g_reg
      logic              hit;
      logic [DATA_W-1:0] q;
      logic              stb_q;

      assign hit = wr_req && (dec == DEC_RW) && (idx == IDX_W'(g));

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            q     <= '0;
            stb_q <= 1'b0;
         end else begin
            if (hit)
               q <= DATA_W'(merge_lanes(32'(q), 32'(dat_i), 4'(sel_i)));
            stb_q <= hit;
         end
      end

      assign regs_o[g*DATA_W +: DATA_W] = q;
      assign wr_stb_o[g]                = stb_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         dat_o <= '0;
      end else begin
         ack_o <= req && (dec != DEC_ERR);
         err_o <= req && (dec == DEC_ERR);
         dat_o <= (req && !we_i && (dec != DEC_ERR)) ? rd_word : '0;
      end
   end

`ifdef WB_REG_BANK_IRQ_EN
   wb_reg_bank_irq #(.DATA_W(DATA_W)) u_irq (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .irq_src_i (irq_src_i),
      .pend_we   (wr_req && (dec == DEC_PEND)),
      .mask_we   (wr_req && (dec == DEC_MASK)),
      .sel_i     (sel_i),
      .dat_i     (dat_i),
      .pend_o    (pend_w),
      .mask_o    (mask_w),
      .irq_o     (irq_o)
   );
`else
   assign pend_w = '0;
   assign mask_w = '0;
`endif

endmodule
